// File: rtl/pc_flag_unit_pkg.sv
// Shared constants for the PC / flag unit: condition codes, flag bit indices
// and the RUN/HALTED state encoding.
package pc_flag_unit_pkg;

   localparam logic [2:0] CCC_NE     = 3'b000;
   localparam logic [2:0] CCC_EQ     = 3'b001;
   localparam logic [2:0] CCC_GT     = 3'b010;
   localparam logic [2:0] CCC_LT     = 3'b011;
   localparam logic [2:0] CCC_GE     = 3'b100;
   localparam logic [2:0] CCC_LE     = 3'b101;
   localparam logic [2:0] CCC_OV     = 3'b110;
   localparam logic [2:0] CCC_UNCOND = 3'b111;

   localparam int FLAG_N = 0;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 2;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

endpackage

// File: rtl/claAddSub.sv
// Carry-lookahead adder/subtractor built from 4-bit lookahead groups;
// W must be a multiple of 4.
module claAddSub #(
   parameter int W = 16
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_is_sub,
   output logic [W-1:0] o_sum
);

   logic [W-1:0] w_b;
   logic [W-1:0] w_g;
   logic [W-1:0] w_p;

   assign w_b = i_b ^ {W{i_is_sub}};
   assign w_g = i_a & w_b;
   assign w_p = i_a ^ w_b;

   // Carry enters each group from the previous group's lookahead G/P terms.
   always_comb begin
      logic       c;
      logic [3:0] gc;
      logic [3:0] g4;
      logic [3:0] p4;
      o_sum = '0;
      c     = i_is_sub;
      gc    = '0;
      g4    = '0;
      p4    = '0;
      for (int grp = 0; grp < W / 4; grp++) begin
         g4    = w_g[grp*4 +: 4];
         p4    = w_p[grp*4 +: 4];
         gc[0] = c;
         gc[1] = g4[0] | (p4[0] & c);
         gc[2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & c);
         gc[3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
               | (p4[2] & p4[1] & p4[0] & c);
         o_sum[grp*4 +: 4] = p4 ^ gc;
         c = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
           | (p4[3] & p4[2] & p4[1] & g4[0]) | ((&p4) & c);
      end
   end

endmodule

// File: rtl/pc_flag_unit_cond.sv
// Branch condition evaluator: maps a condition code and the registered
// N/V/Z flags onto a single taken-if-branch bit.
module branch_cond_eval
   import pc_flag_unit_pkg::*;
(
   input  logic [2:0] i_ccc,
   input  logic [2:0] i_flag,
   output logic       o_cond
);

   logic w_n;
   logic w_v;
   logic w_z;

   assign w_n = i_flag[FLAG_N];
   assign w_v = i_flag[FLAG_V];
   assign w_z = i_flag[FLAG_Z];

   always_comb begin
      o_cond = 1'b0;
      case (i_ccc)
         CCC_NE:     o_cond = !w_z;
         CCC_EQ:     o_cond = w_z;
         CCC_GT:     o_cond = !w_z && !w_n;
         CCC_LT:     o_cond = w_n;
         CCC_GE:     o_cond = w_z || !w_n;
         CCC_LE:     o_cond = w_z || w_n;
         CCC_OV:     o_cond = w_v;
         CCC_UNCOND: o_cond = 1'b1;
         default:    o_cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_flag_unit.sv
// Program counter, architectural N/V/Z flag register and RUN/HALTED control.
// Branches resolve against registered flags; the redirect lands on pc next cycle.
module pc_flag_unit
   import pc_flag_unit_pkg::*;
#(
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [2:0]      alu_flag,
   input  logic            flag_we,
   input  logic            stall,
   input  logic            is_b,
   input  logic            is_br,
   input  logic [2:0]      ccc,
   input  logic [8:0]      imm9,
   input  logic [PC_W-1:0] br_target,
   input  logic            halt,
   output logic [2:0]      flag_q,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] pc_plus2,
   output logic            taken,
   output logic            halted
);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [PC_W-1:0] r_pc;
   logic [2:0]      r_flag;
   logic            w_run;
   logic            w_cond;
   logic [PC_W-1:0] w_pc_plus2;
   logic [PC_W-1:0] w_b_off;
   logic [PC_W-1:0] w_b_target;
   logic [PC_W-1:0] w_pc_nxt;

   branch_cond_eval u_cond (
      .i_ccc  (ccc),
      .i_flag (r_flag),
      .o_cond (w_cond)
   );

   claAddSub #(.W(PC_W)) u_pc_inc (
      .i_a      (r_pc),
      .i_b      (PC_W'(2)),
      .i_is_sub (1'b0),
      .o_sum    (w_pc_plus2)
   );

   // Word offset: sign-extended imm9 shifted left one bit.
   assign w_b_off = {{(PC_W-10){imm9[8]}}, imm9, 1'b0};

   claAddSub #(.W(PC_W)) u_br_add (
      .i_a      (w_pc_plus2),
      .i_b      (w_b_off),
      .i_is_sub (1'b0),
      .o_sum    (w_b_target)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= RUN;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      if (r_state == RUN && halt && !stall) w_state_nxt = HALTED;
   end

   // State-derived outputs
   always_comb begin
      w_run  = (r_state == RUN);
      halted = (r_state == HALTED);
   end

   assign taken = (is_b || is_br) && w_cond && w_run && !halt;

   always_comb begin
      w_pc_nxt = w_pc_plus2;
      if (taken) begin
         if (is_br) w_pc_nxt = {br_target[PC_W-1:1], 1'b0};
         else       w_pc_nxt = w_b_target;
      end
   end

   // A HLT cycle keeps pc on the HLT address.
   always_ff @(posedge clk) begin
      if (rst)                         r_pc <= RESET_PC;
      else if (w_run && !stall && !halt) r_pc <= w_pc_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst)                            r_flag <= 3'b000;
      else if (w_run && !stall && flag_we) r_flag <= alu_flag;
   end

   assign flag_q   = r_flag;
   assign pc       = r_pc;
   assign pc_plus2 = w_pc_plus2;

endmodule

// File: tb/tb_pc_flag_unit.sv
// Bench for pc_flag_unit: directed scenarios followed by random traffic, all
// checked against an arithmetic reference model of the PC and flag rules.
module tb_pc_flag_unit;

   logic        clk;
   logic        rst;
   logic [2:0]  alu_flag;
   logic        flag_we;
   logic        stall;
   logic        is_b;
   logic        is_br;
   logic [2:0]  ccc;
   logic [8:0]  imm9;
   logic [15:0] br_target;
   logic        halt;
   logic [2:0]  flag_q;
   logic [15:0] pc;
   logic [15:0] pc_plus2;
   logic        taken;
   logic        halted;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int   m_pc;
   logic [2:0] m_flags;
   logic m_halted;
   logic m_valid = 1'b0;

   pc_flag_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
      .clk       (clk),
      .rst       (rst),
      .alu_flag  (alu_flag),
      .flag_we   (flag_we),
      .stall     (stall),
      .is_b      (is_b),
      .is_br     (is_br),
      .ccc       (ccc),
      .imm9      (imm9),
      .br_target (br_target),
      .halt      (halt),
      .flag_q    (flag_q),
      .pc        (pc),
      .pc_plus2  (pc_plus2),
      .taken     (taken),
      .halted    (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic cond_holds(input logic [2:0] c, input logic [2:0] f);
      logic n, v, z;
      n = f[0];
      v = f[1];
      z = f[2];
      case (c)
         3'd0: return !z;
         3'd1: return z;
         3'd2: return !z && !n;
         3'd3: return n;
         3'd4: return z || !n;
         3'd5: return z || n;
         3'd6: return v;
         default: return 1'b1;
      endcase
   endfunction

   task automatic idle_inputs();
      rst = 0; alu_flag = 3'b000; flag_we = 0; stall = 0; is_b = 0; is_br = 0;
      ccc = 3'b000; imm9 = 9'h000; br_target = 16'h0000; halt = 0;
   endtask

   // One clock: check taken before the edge, advance model, check state after.
   task automatic tick();
      logic exp_taken;
      int   off;
      #1;
      exp_taken = (is_b || is_br) && cond_holds(ccc, m_flags) && !m_halted && !halt;
      if (m_valid && !rst) chk("taken", 32'(taken), 32'(exp_taken));
      @(posedge clk);
      if (rst) begin
         m_pc = 0; m_flags = 3'b000; m_halted = 1'b0; m_valid = 1'b1;
      end else if (!m_halted && !stall) begin
         if (flag_we) m_flags = alu_flag;
         if (halt) m_halted = 1'b1;
         else if (exp_taken && is_br) m_pc = int'(br_target) & 32'hFFFE;
         else if (exp_taken) begin
            off  = imm9[8] ? int'(imm9) - 512 : int'(imm9);
            m_pc = (m_pc + 2 + 2 * off) & 32'hFFFF;
         end else m_pc = (m_pc + 2) & 32'hFFFF;
      end
      #1;
      chk("pc", 32'(pc), 32'(m_pc));
      chk("flag_q", 32'(flag_q), 32'(m_flags));
      chk("halted", 32'(halted), 32'(m_halted));
      chk("pc_plus2", 32'(pc_plus2), 32'((m_pc + 2) & 32'hFFFF));
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         idle_inputs();
         tick();
      end
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      tick();
      tick();
      rst = 0;
   endtask

   initial begin
      idle_inputs();
      @(posedge clk);
      #1;

      // 1. reset and sequential fetch
      do_reset();
      chk("reset_pc", 32'(pc), 32'h0000);
      chk("reset_flags", 32'(flag_q), 32'h0);
      chk("reset_halted", 32'(halted), 32'h0);
      idle_cycles(4);
      chk("idle_pc", 32'(pc), 32'h0008);

      // 2. flag write, then EQ branch from 0x0010
      idle_cycles(3);
      idle_inputs(); flag_we = 1; alu_flag = 3'b100; tick();
      chk("pc_0010", 32'(pc), 32'h0010);
      idle_inputs(); is_b = 1; ccc = 3'b001; imm9 = 9'h004;
      #1; chk("eq_taken", 32'(taken), 32'h1);
      tick();
      chk("eq_target", 32'(pc), 32'h001A);

      // 3. N=1: GT not taken, LT taken; also same-cycle flag write must not matter
      idle_inputs(); flag_we = 1; alu_flag = 3'b001; tick();
      idle_inputs(); is_b = 1; ccc = 3'b010; imm9 = 9'h010;
      flag_we = 1; alu_flag = 3'b000;
      tick();
      idle_inputs(); flag_we = 1; alu_flag = 3'b001; tick();
      idle_inputs(); is_b = 1; ccc = 3'b011; imm9 = 9'h010;
      flag_we = 1; alu_flag = 3'b000;
      #1; chk("lt_taken_old_flags", 32'(taken), 32'h1);
      tick();

      // 4. negative offset wraps below zero
      do_reset();
      idle_cycles(2);
      idle_inputs(); is_b = 1; ccc = 3'b111; imm9 = 9'h1FC; tick();
      chk("wrap_neg", 32'(pc), 32'hFFFE);
      idle_cycles(2);
      chk("wrap_pos", 32'(pc), 32'h0002);

      // 5. register-indirect on overflow, then the same under stall
      idle_inputs(); flag_we = 1; alu_flag = 3'b010; tick();
      idle_inputs(); is_br = 1; ccc = 3'b110; br_target = 16'h1235; tick();
      chk("br_target", 32'(pc), 32'h1234);
      idle_inputs(); is_br = 1; ccc = 3'b110; br_target = 16'h5679; stall = 1;
      flag_we = 1; alu_flag = 3'b100; tick();
      chk("stall_hold", 32'(pc), 32'h1234);
      // is_br wins when both branch kinds are raised
      idle_inputs(); is_br = 1; is_b = 1; ccc = 3'b111; br_target = 16'h0100; imm9 = 9'h020;
      tick();
      chk("br_priority", 32'(pc), 32'h0100);

      // 6. halt with an unconditional branch alongside
      do_reset();
      idle_cycles(16);
      idle_inputs(); halt = 1; is_b = 1; ccc = 3'b111; imm9 = 9'h040;
      flag_we = 1; alu_flag = 3'b110;
      #1; chk("halt_not_taken", 32'(taken), 32'h0);
      tick();
      chk("halt_pc", 32'(pc), 32'h0020);
      chk("halt_flags_written", 32'(flag_q), 32'h6);
      for (int i = 0; i < 5; i++) begin
         idle_inputs();
         is_b = 1; ccc = 3'b111; flag_we = 1; alu_flag = 3'($urandom_range(7));
         stall = 1'($urandom_range(1));
         tick();
      end
      chk("halted_pc", 32'(pc), 32'h0020);
      chk("halted_flag", 32'(halted), 32'h1);
      idle_inputs(); rst = 1; tick(); rst = 0;
      chk("rst_from_halt_pc", 32'(pc), 32'h0000);
      chk("rst_from_halt", 32'(halted), 32'h0);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         idle_inputs();
         rst       = ($urandom_range(59) == 0);
         halt      = ($urandom_range(29) == 0);
         stall     = ($urandom_range(4) == 0);
         flag_we   = 1'($urandom_range(1));
         alu_flag  = 3'($urandom_range(7));
         is_b      = 1'($urandom_range(1));
         is_br     = ($urandom_range(3) == 0);
         ccc       = 3'($urandom_range(7));
         imm9      = 9'($urandom_range(511));
         br_target = 16'($urandom_range(65535));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
